// File: rtl/prbs_lock_monitor.sv
// -----------------------------------------------------------------------------
// prbs_lock_monitor
//
// PRBS-31 (x^31 + x^28 + 1) checker for a 32-bit receive stream. In HUNT the
// predictor is reseeded from every received beat, and a run of good beats
// declares lock. In LOCKED the predictor free-runs and a run of errored beats
// drops lock. Error, frame and frame-error counters saturate at all-ones.
//
// Optional build macro:
//   PRBS_BIT_ERR_CNT_EN : err_cnt_o accumulates mismatched bits per errored
//                         beat instead of counting errored beats.
//
// Parameters:
//   LOCK_CNT   : consecutive good beats in HUNT needed to lock
//   UNLOCK_CNT : consecutive errored beats in LOCKED that drop lock
//   CNT_W      : width of err_cnt_o / frame_cnt_o (must be >= 6)
//
// Ports:
//   rx_user_clk_i   : clock, all logic on the rising edge
//   rx_user_rst_n_i : synchronous active-low reset
//   rx_data_i       : received beat, bit 0 is the oldest PRBS bit
//   rx_vldb_i       : valid bytes minus 1 on the last beat
//   rx_valid_i      : beat valid
//   rx_last_i       : end of frame
//   rx_user_i       : MAC frame-error flag, sampled with rx_last_i
//   clear_i         : synchronous counter clear
//   locked_o        : checker is in LOCKED
//   err_o           : one-cycle pulse per errored beat while LOCKED
//   err_cnt_o       : saturating error count
//   frame_cnt_o     : saturating completed-frame count
//   frame_err_cnt_o : saturating count of frames flagged by rx_user_i
// -----------------------------------------------------------------------------
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_HUNT   | reseed predictor from each beat, count consecutive good beats
// ST_LOCKED | predictor free-runs, count consecutive errored beats

module prbs_lock_monitor #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             rx_user_clk_i,
  input  logic             rx_user_rst_n_i,
  input  logic [31:0]      rx_data_i,
  input  logic [1:0]       rx_vldb_i,
  input  logic             rx_valid_i,
  input  logic             rx_last_i,
  input  logic             rx_user_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [15:0]      frame_err_cnt_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pred_q, pred_d;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [15:0]      frame_err_cnt_q, frame_err_cnt_d;

  logic [31:0]      expected;
  logic [31:0]      byte_mask;
  logic [31:0]      mism;
  logic             beat_bad;
  logic [5:0]       bit_errs;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W:0]   err_sum;

  // pred holds the previous beat (32 bits, bit 0 oldest). The next beat is
  // unrolled bit by bit: stream bit n = bit(n-31) ^ bit(n-28), which in the
  // 64-bit window {next, prev} is e[32+n] = e[n+1] ^ e[n+4].
  function automatic logic [31:0] prbs_next32(input logic [31:0] prev);
    logic [63:0] e;
    e = {32'h0, prev};
    for (int n = 0; n < 32; n++) begin
      e[32+n] = e[n+1] ^ e[n+4];
    end
    return e[63:32];
  endfunction

  always_comb begin
    expected = prbs_next32(pred_q);

    byte_mask = '1;
    if (rx_last_i) begin
      for (int k = 0; k < 4; k++) begin
        byte_mask[8*k +: 8] = (2'(k) <= rx_vldb_i) ? 8'hFF : 8'h00;
      end
    end

    mism     = (rx_data_i ^ expected) & byte_mask;
    beat_bad = |mism;

    bit_errs = '0;
    for (int i = 0; i < 32; i++) begin
      bit_errs = bit_errs + 6'(mism[i]);
    end
  end

`ifdef PRBS_BIT_ERR_CNT_EN
  assign err_inc = CNT_W'(bit_errs);
`else
  assign err_inc = CNT_W'(1);
`endif

  // Lock FSM and predictor
  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;

    if (rx_valid_i) begin
      case (state_q)
        ST_HUNT: begin
          pred_d = rx_data_i;
          if (beat_bad) begin
            good_d = '0;
          end else if (good_q == GW'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end

        ST_LOCKED: begin
          pred_d = expected;
          if (beat_bad) begin
            err_d = 1'b1;
            if (bad_q == BW'(UNLOCK_CNT - 1)) begin
              state_d = ST_HUNT;
              bad_d   = '0;
              good_d  = '0;
              // The unlocking beat acts as the first HUNT seed, so a
              // clean stream needs a fresh seed plus LOCK_CNT good beats.
              pred_d  = rx_data_i;
            end else begin
              bad_d = bad_q + BW'(1);
            end
          end else begin
            bad_d = '0;
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  // Statistics counters; clear_i wins over any same-cycle event
  always_comb begin
    err_cnt_d       = err_cnt_q;
    frame_cnt_d     = frame_cnt_q;
    frame_err_cnt_d = frame_err_cnt_q;
    err_sum         = {1'b0, err_cnt_q} + {1'b0, err_inc};

    if (clear_i) begin
      err_cnt_d       = '0;
      frame_cnt_d     = '0;
      frame_err_cnt_d = '0;
    end else if (rx_valid_i) begin
      if (state_q == ST_LOCKED && beat_bad) begin
        err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      end
      if (rx_last_i) begin
        if (frame_cnt_q != '1) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (rx_user_i && frame_err_cnt_q != '1) begin
          frame_err_cnt_d = frame_err_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge rx_user_clk_i) begin
    if (!rx_user_rst_n_i) begin
      state_q         <= ST_HUNT;
      pred_q          <= '0;
      good_q          <= '0;
      bad_q           <= '0;
      err_q           <= 1'b0;
      err_cnt_q       <= '0;
      frame_cnt_q     <= '0;
      frame_err_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      pred_q          <= pred_d;
      good_q          <= good_d;
      bad_q           <= bad_d;
      err_q           <= err_d;
      err_cnt_q       <= err_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
      frame_err_cnt_q <= frame_err_cnt_d;
    end
  end

  assign locked_o        = (state_q == ST_LOCKED);
  assign err_o           = err_q;
  assign err_cnt_o       = err_cnt_q;
  assign frame_cnt_o     = frame_cnt_q;
  assign frame_err_cnt_o = frame_err_cnt_q;

endmodule

// File: tb/tb_prbs_lock_monitor.sv
// -----------------------------------------------------------------------------
// tb_prbs_lock_monitor
//
// Directed stimulus for prbs_lock_monitor. Each driven cycle pushes the
// expected outputs for the following edge into a queue; an independent
// monitor pops one entry per clock and compares it with the DUT outputs.
// PRBS-31 data comes from a bit-serial shift-register generator.
// -----------------------------------------------------------------------------

module tb_prbs_lock_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic [1:0]  vldb = '0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        user = 1'b0;
  logic        clr = 1'b0;
  logic        locked_o;
  logic        err_o;
  logic [31:0] err_cnt_o;
  logic [31:0] frame_cnt_o;
  logic [15:0] frame_err_cnt_o;

  always #5 clk = ~clk;

  prbs_lock_monitor dut (
    .rx_user_clk_i   (clk),
    .rx_user_rst_n_i (rst_n),
    .rx_data_i       (data),
    .rx_vldb_i       (vldb),
    .rx_valid_i      (valid),
    .rx_last_i       (last),
    .rx_user_i       (user),
    .clear_i         (clr),
    .locked_o        (locked_o),
    .err_o           (err_o),
    .err_cnt_o       (err_cnt_o),
    .frame_cnt_o     (frame_cnt_o),
    .frame_err_cnt_o (frame_err_cnt_o)
  );

  typedef struct {
    bit          chk;
    logic        lock;
    logic        err;
    logic [31:0] ec;
    logic [31:0] fc;
    logic [15:0] fec;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   fails = 0;
  int   next_id = 0;

  // expected output state, updated by hand as the sequence progresses
  logic        e_lock;
  logic [31:0] e_ec;
  logic [31:0] e_fc;
  logic [15:0] e_fec;

  logic [30:0] lfsr = 31'h1234_5678;

  // bit-serial PRBS-31: lfsr[0] is bit n-1, lfsr[30] is bit n-31
  task automatic gen_beat(output logic [31:0] d);
    logic nb;
    for (int i = 0; i < 32; i++) begin
      nb   = lfsr[30] ^ lfsr[27];
      d[i] = nb;
      lfsr = {lfsr[29:0], nb};
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d,
                       input logic [1:0] vb, input logic l, input logic u,
                       input logic c, input logic x_err, input bit chk);
    exp_t e;
    @(negedge clk);
    rst_n = r; valid = v; data = d; vldb = vb; last = l; user = u; clr = c;
    e.chk = chk; e.lock = e_lock; e.err = x_err;
    e.ec = e_ec; e.fc = e_fc; e.fec = e_fec; e.id = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] vb, input logic l,
                      input logic u, input logic c, input logic x_err);
    drive(1'b1, 1'b1, d, vb, l, u, c, x_err, 1'b1);
  endtask

  task automatic clean_beat();
    logic [31:0] d;
    gen_beat(d);
    beat(d, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: one scoreboard entry per clock, sampled 1 time unit after the edge
  initial begin
    exp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        if (r.chk) begin
          vecs++;
          if (locked_o !== r.lock || err_o !== r.err || err_cnt_o !== r.ec ||
              frame_cnt_o !== r.fc || frame_err_cnt_o !== r.fec) begin
            fails++;
            $display("FAIL vec%0d: got lock=%0b err=%0b err_cnt=%0d frame_cnt=%0d frame_err_cnt=%0d, want lock=%0b err=%0b err_cnt=%0d frame_cnt=%0d frame_err_cnt=%0d",
                     r.id, locked_o, err_o, err_cnt_o, frame_cnt_o, frame_err_cnt_o,
                     r.lock, r.err, r.ec, r.fc, r.fec);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    e_lock = 1'b0; e_ec = '0; e_fc = '0; e_fec = '0;

    // reset, then an idle cycle carrying garbage
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'h1234_5678, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'hCAFE_F00D, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // acquisition: 1 seed + 16 good beats, idle gap in the middle
    for (int b = 1; b <= 17; b++) begin
      if (b == 9) drive(1'b1, 1'b0, 32'h0BAD_0BAD, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      e_lock = (b == 17);
      clean_beat();
    end
    clean_beat();
    clean_beat();

    // single bit-5 flip while locked
    gen_beat(d);
    e_ec = 1;
    beat(d ^ 32'h0000_0020, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    clean_beat();

    // six more isolated single-bit errors -> err_cnt 7
    for (int k = 0; k < 6; k++) begin
      gen_beat(d);
      e_ec = e_ec + 1;
      beat(d ^ (32'h1 << (k * 5 + 1)), 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      clean_beat();
    end

    // clear coincident with an errored beat
    gen_beat(d);
    e_ec = 0; e_fc = 0; e_fec = 0;
    beat(d ^ 32'h0000_0020, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    clean_beat();

    // last beat, only byte 0 valid, bytes 1..3 corrupted
    gen_beat(d);
    e_fc = 1;
    beat(d ^ 32'hFFFF_FF00, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    clean_beat();

    // clean last beat flagged by the MAC
    gen_beat(d);
    e_fc = 2; e_fec = 1;
    beat(d, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // last beat with bytes 0..1 valid, error in byte 1
    gen_beat(d);
    e_fc = 3; e_ec = e_ec + 1;
    beat(d ^ 32'h0000_0100, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    clean_beat();

    // eight bit errors in one beat
    gen_beat(d);
`ifdef PRBS_BIT_ERR_CNT_EN
    e_ec = e_ec + 8;
`else
    e_ec = e_ec + 1;
`endif
    beat(d ^ 32'h0000_00FF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    clean_beat();

    // four consecutive errored beats drop lock on the fourth
    for (int b = 1; b <= 4; b++) begin
      gen_beat(d);
      e_ec = e_ec + 1;
      e_lock = (b != 4);
      beat(d ^ 32'h0000_0020, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // relock needs 17 clean beats; HUNT mismatches never raise err_o
    for (int b = 1; b <= 17; b++) begin
      e_lock = (b == 17);
      clean_beat();
    end

    // reset in the middle of a frame
    clean_beat();
    e_lock = 0; e_ec = 0; e_fc = 0; e_fec = 0;
    gen_beat(d);
    drive(1'b0, 1'b1, d, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'h5555_AAAA, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    clean_beat();

    // frame_err_cnt saturation (16-bit) with a non-locking stream
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65534; i++) begin
      drive(1'b1, 1'b1, 32'hFFFF_FFFF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    e_fc = 65535; e_fec = 16'hFFFF;
    beat(32'hFFFF_FFFF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    e_fc = 65536;
    beat(32'hFFFF_FFFF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left in scoreboard, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
